systemverilog_bus_arbiter: RTL and testbench
============================================

SYSTEMVERILOG_BUS_ARBITER -- requirements
Module: systemverilog_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port is named clk, reset port is named rst_n.
REQ-002 The block SHALL have parameter N, default 4, number of requesting bus masters (2..8).
REQ-003 The block SHALL have parameter AW, default 32, address width.
REQ-004 The block SHALL have parameter DW, default 32, data width.
REQ-005 The block SHALL have parameter BURST, default 4, maximum transfers per grant (1..255).
REQ-006 The block SHALL have the following ports:
  clk     input   1      system clock, all state on rising edge
  rst_n   input   1      asynchronous active-low reset
  m_vld   input   N      per-master valid
  m_adr   input   N*AW   per-master address, master i at bits [i*AW +: AW]
  m_dat   input   N*DW   per-master data, master i at bits [i*DW +: DW]
  m_rdy   output  N      per-master ready
  s_vld   output  1      shared bus valid
  s_adr   output  AW     shared bus address
  s_dat   output  DW     shared bus data
  s_rdy   input   1      shared bus ready
  gnt     output  N      one-hot current grant, registered
  busy    output  1      high in state GRANT

Function
REQ-007 The FSM SHALL have two states, IDLE and GRANT; gnt SHALL be all-zero in IDLE and one-hot in GRANT.
REQ-008 In IDLE with any m_vld high, the FSM SHALL select the first requester found searching from index ptr+1 upward, modulo N. It SHALL load gnt with that index, load ptr with that index, clear the burst counter and enter GRANT on the next edge.
REQ-009 Arbitration latency SHALL be exactly 1 cycle: a request seen in IDLE at edge k yields gnt at edge k+1.
REQ-010 In GRANT with granted index g: s_vld=m_vld[g], s_adr=m_adr[g], s_dat=m_dat[g] and m_rdy[g]=s_rdy, all combinational; every other m_rdy bit SHALL be 0.
REQ-011 In IDLE: s_vld=0, m_rdy=0, and s_adr/s_dat SHALL be 0.
REQ-012 A transfer SHALL be counted when s_vld & s_rdy is high at a rising edge; the burst counter is 8-bit and increments per transfer.
REQ-013 GRANT SHALL return to IDLE (gnt cleared) at the edge where either condition holds:
  - m_vld[g]=0;
  - a transfer occurs and the counter equals BURST-1.
REQ-014 After release, at least one IDLE cycle SHALL occur before the next grant, including a re-grant to the same master.
REQ-015 Round-robin fairness: a master that just held the grant SHALL have the lowest priority in the next arbitration; no continuously requesting master waits more than N-1 grants.
REQ-016 A requester whose m_vld deasserts before being granted SHALL lose its place with no side effect; m_vld changes of non-granted masters SHALL NOT affect the current grant.
REQ-017 With BURST=1, every transfer SHALL release the grant.

Reset
REQ-018 While rst_n=0, asynchronously: state=IDLE, gnt=0, busy=0, burst counter=0, ptr=N-1 (first search starts at index 0); all outputs per REQ-011.
REQ-019 Reset asserted mid-burst SHALL abort the grant immediately; m_rdy SHALL go to 0 without waiting for a clock edge.
REQ-020 First arbitration after reset release SHALL occur at the first rising edge with rst_n=1.

Verification
REQ-021 Single request, N=4, BURST=4: m_vld=4'b0100 held, s_rdy=1 -> gnt=4'b0100 one cycle after request; 4 transfers; release; one IDLE cycle; re-grant to master 2.
REQ-022 All request, s_rdy=1: m_vld=4'b1111 -> grant order 0,1,2,3,0, each for 4 transfers, with an IDLE cycle between grants.
REQ-023 Early release: master 1 granted, drops m_vld after 2 transfers, master 3 requesting -> return to IDLE; next gnt=4'b1000; counter restarts at 0.
REQ-024 Backpressure: master 0 granted, s_rdy low for 5 cycles then high -> gnt held, no count change while s_rdy=0, m_rdy[0] mirrors s_rdy, other m_rdy bits 0.
REQ-025 Reset mid-burst: master 2 granted after 2 transfers, rst_n pulsed low -> gnt=0 and m_rdy=0 asynchronously; after release, m_vld=4'b0110 -> master 1 granted first (ptr=N-1).
REQ-026 Scoreboard: per-master address/data sequences on the shared bus SHALL match the sequences each master issued; no beat is lost or duplicated.

Source files
------------

// File: rtl/systemverilog_bus_arbiter.sv
// Round-robin arbiter granting one of N masters access to a shared bus.
// A grant lasts until the master drops its valid or BURST beats have moved,
// and every release is followed by at least one IDLE cycle.
//
//   state | meaning
//   IDLE  | no owner; bus outputs forced to zero, searching for a requester
//   GRANT | master ptr_q owns the bus; its valid/addr/data/ready are muxed through
module systemverilog_bus_arbiter #(
  parameter int N     = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    m_vld,
  input  logic [N*AW-1:0] m_adr,
  input  logic [N*DW-1:0] m_dat,
  output logic [N-1:0]    m_rdy,
  output logic            s_vld,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat,
  input  logic            s_rdy,
  output logic [N-1:0]    gnt,
  output logic            busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] sel, idx;
  logic          found;
  logic          xfer;

  logic [AW-1:0] adr_arr [N];
  logic [DW-1:0] dat_arr [N];

  // Split the flat master buses into per-master words
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign adr_arr[gi] = m_adr[gi*AW +: AW];
    assign dat_arr[gi] = m_dat[gi*DW +: DW];
  end

  // First requester after the last owner; ptr_q holds the last owner, so
  // that master is naturally searched last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && m_vld[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Shared-bus mux; everything zero unless a grant is active
  always_comb begin
    s_vld = 1'b0;
    s_adr = '0;
    s_dat = '0;
    m_rdy = '0;
    if (state_q == GRANT) begin
      s_vld        = m_vld[ptr_q];
      s_adr        = adr_arr[ptr_q];
      s_dat        = dat_arr[ptr_q];
      m_rdy[ptr_q] = s_rdy;
    end
  end

  assign xfer = (state_q == GRANT) && s_vld && s_rdy;

  // Next-state: grant on any request, release on valid drop or final beat
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          ptr_d      = sel;
          cnt_d      = 8'd0;
        end
      end
      GRANT: begin
        if (!m_vld[ptr_q] || (xfer && (cnt_q == BURST_LAST))) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State register; reset aborts any grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= IW'(N - 1);
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_systemverilog_bus_arbiter.sv
// Directed bench for the round-robin bus arbiter (N=4, BURST=4).
// Each master presents a numbered beat; the beat is queued when presented
// and popped when it crosses the shared bus.
module tb_systemverilog_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_vld;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N-1:0]    m_rdy;
  logic            s_vld;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat;
  logic            s_rdy;
  logic [N-1:0]    gnt;
  logic            busy;

  systemverilog_bus_arbiter #(.N(N), .AW(AW), .DW(DW), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_vld(m_vld), .m_adr(m_adr), .m_dat(m_dat), .m_rdy(m_rdy),
    .s_vld(s_vld), .s_adr(s_adr), .s_dat(s_dat), .s_rdy(s_rdy),
    .gnt(gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beat_no [N];
  int    xfers   [N];
  bit    hs      [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int i);
    beat_t b;
    b.idx = i;
    b.adr = 32'hA000_0000 | (i << 16) | beat_no[i];
    b.dat = 32'hD000_0000 | (i << 20) | (beat_no[i] * 3);
    m_adr[i*AW +: AW] = b.adr;
    m_dat[i*DW +: DW] = b.dat;
    sb_q.push_back(b);
  endtask

  // One clock: score any handshake at the negedge, then advance masters
  task automatic step();
    int g;
    int pos;
    @(negedge clk);
    if (rst_n && s_vld && s_rdy) begin
      g = 0;
      for (int i = 0; i < N; i++) if (gnt[i]) g = i;
      pos = -1;
      for (int j = 0; j < sb_q.size(); j++)
        if (pos < 0 && sb_q[j].idx == g) pos = j;
      checks++;
      assert (pos >= 0) else begin
        errors++;
        $error("FAIL sb_lookup: observed no pending beat for master %0d expected one", g);
      end
      if (pos >= 0) begin
        chk("sb_adr", s_adr, sb_q[pos].adr);
        chk("sb_dat", s_dat, sb_q[pos].dat);
        sb_q.delete(pos);
        hs[g] = 1'b1;
        xfers[g]++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        hs[i] = 1'b0;
        beat_no[i]++;
        present(i);
      end
    end
    #1;
  endtask

  task automatic burst4(input string tag, input logic [3:0] g);
    for (int b = 0; b < 4; b++) begin
      step();
      if (b < 3) begin
        chk({tag, "_hold"}, gnt, g);
        chk({tag, "_rdy"}, m_rdy, g);
      end else begin
        chk({tag, "_rel"}, gnt, 4'b0000);
        chk({tag, "_idle"}, busy, 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of run expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_g;
    int x0;
    rst_n = 1'b0;
    m_vld = '0;
    m_adr = '0;
    m_dat = '0;
    s_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      beat_no[i] = 0;
      xfers[i]   = 0;
      hs[i]      = 1'b0;
      present(i);
    end

    // Reset holds everything quiet even with all masters requesting
    m_vld = 4'b1111;
    step();
    step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mrdy", m_rdy, 4'b0000);
    chk("rst_svld", s_vld, 1'b0);
    chk("rst_sadr", s_adr, 32'h0);
    chk("rst_sdat", s_dat, 32'h0);

    // All requesting: 0,1,2,3,0 each for 4 beats, IDLE between grants
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step();
      chk("rr_gnt", gnt, exp_g);
      chk("rr_busy", busy, 1'b1);
      burst4("rr", exp_g);
    end
    m_vld = 4'b0000;
    step();

    // Single requester: grant one cycle later, 4 beats, IDLE, re-grant
    m_vld = 4'b0100;
    step();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_sadr", s_adr, m_adr[2*AW +: AW]);
    burst4("single", 4'b0100);
    step();
    chk("single_regnt", gnt, 4'b0100);
    m_vld = 4'b0000;
    step();
    chk("single_drop", gnt, 4'b0000);

    // Early release: master 1 drops after 2 beats, master 3 takes over
    m_vld = 4'b0010;
    step();
    chk("early_gnt1", gnt, 4'b0010);
    m_vld = 4'b1010;
    step();
    step();
    chk("early_hold", gnt, 4'b0010);
    chk("early_x1", xfers[1], 32'd6);
    m_vld = 4'b1000;
    step();
    chk("early_rel", gnt, 4'b0000);
    step();
    chk("early_gnt3", gnt, 4'b1000);
    burst4("early3", 4'b1000);
    m_vld = 4'b0000;
    step();

    // Backpressure on master 0; master 2 pulses its valid meanwhile
    m_vld = 4'b0001;
    step();
    chk("bp_gnt", gnt, 4'b0001);
    s_rdy = 1'b0;
    m_vld = 4'b0101;
    x0 = xfers[0];
    for (int c = 0; c < 5; c++) begin
      if (c == 2) m_vld = 4'b0001;
      step();
      chk("bp_hold", gnt, 4'b0001);
      chk("bp_mrdy0", m_rdy, 4'b0000);
      chk("bp_svld", s_vld, 1'b1);
    end
    chk("bp_nocount", xfers[0], x0);
    s_rdy = 1'b1;
    #1;
    chk("bp_mrdy1", m_rdy, 4'b0001);
    burst4("bp", 4'b0001);
    m_vld = 4'b0000;
    step();

    // Reset mid-burst on master 2, then ptr restarts at N-1
    m_vld = 4'b0100;
    step();
    chk("mid_gnt", gnt, 4'b0100);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_gnt0", gnt, 4'b0000);
    chk("mid_mrdy0", m_rdy, 4'b0000);
    chk("mid_busy0", busy, 1'b0);
    chk("mid_svld0", s_vld, 1'b0);
    step();
    rst_n = 1'b1;
    m_vld = 4'b0110;
    step();
    chk("post_rst_gnt", gnt, 4'b0010);
    m_vld = 4'b0000;
    step();
    chk("post_rst_rel", gnt, 4'b0000);

    // Beat totals per master and one pending beat per master left over
    chk("tot_m0", xfers[0], 32'd12);
    chk("tot_m1", xfers[1], 32'd6);
    chk("tot_m2", xfers[2], 32'd10);
    chk("tot_m3", xfers[3], 32'd8);
    chk("sb_left", sb_q.size(), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
